data_memory_responder: RTL and testbench



---
 rtl/dmem_pkg.sv | 44 ++++
 rtl/stack_pointer_unit.sv | 49 ++++
 rtl/data_memory_responder.sv | 214 +++++++++++++++++++++
 tb/tb_data_memory_responder.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and default constants for the data-memory responder.
// Contents:
//   state_e : responder FSM states (IDLE, PUSH_LO, POP_HI)
//   op_e    : decoded request class sampled in IDLE
//   DEF_*   : default RAM address width, stack pointer reset value, stack floor
//   decode_op() : turns the four request strobes into one op_e
package dmem_pkg;

    localparam int unsigned DEF_ADDR_W      = 11;
    localparam logic [10:0] DEF_SP_INIT     = 11'h7FF;
    localparam logic [10:0] DEF_STACK_LIMIT = 11'h400;

    typedef enum logic [1:0] {
        IDLE,
        PUSH_LO,
        POP_HI
    } state_e;

    typedef enum logic [2:0] {
        OP_NONE,
        OP_READ,
        OP_WRITE,
        OP_PUSH,
        OP_POP,
        OP_MULTI
    } op_e;

    // More than one strobe high is a single MULTI class so the FSM rejects it
    // without touching RAM or sp.
    function automatic op_e decode_op(input logic rd, input logic wr,
                                      input logic push, input logic pop);
        op_e op;
        case ({rd, wr, push, pop})
            4'b0000: op = OP_NONE;
            4'b1000: op = OP_READ;
            4'b0100: op = OP_WRITE;
            4'b0010: op = OP_PUSH;
            4'b0001: op = OP_POP;
            default: op = OP_MULTI;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/stack_pointer_unit.sv
// Stack pointer register with step controls and the legality flags the
// responder FSM consults before any push or pop.
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   inc1/inc2/dec1/dec2        : step sp by +1/+2/-1/-2 this edge (one at a time)
//   sp                         : current stack pointer (points at next free word)
//   can_push1/can_push2        : room for one/two more words above STACK_LIMIT
//   can_pop1/can_pop2          : at least one/two words on the stack
module stack_pointer_unit
    import dmem_pkg::*;
#(
    parameter int unsigned       ADDR_W      = DEF_ADDR_W,
    parameter logic [ADDR_W-1:0] SP_INIT     = DEF_SP_INIT,
    parameter logic [ADDR_W-1:0] STACK_LIMIT = DEF_STACK_LIMIT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inc1,
    input  logic              inc2,
    input  logic              dec1,
    input  logic              dec2,
    output logic [ADDR_W-1:0] sp,
    output logic              can_push1,
    output logic              can_push2,
    output logic              can_pop1,
    output logic              can_pop2
);

    always_ff @(posedge clk) begin
        if (reset) begin
            sp <= SP_INIT;
        end else if (inc1) begin
            sp <= sp + ADDR_W'(1);
        end else if (inc2) begin
            sp <= sp + ADDR_W'(2);
        end else if (dec1) begin
            sp <= sp - ADDR_W'(1);
        end else if (dec2) begin
            sp <= sp - ADDR_W'(2);
        end
    end

    assign can_push1 = (sp >= STACK_LIMIT);
    // sp-1 >= STACK_LIMIT written without the subtraction so sp=0 cannot wrap.
    assign can_push2 = (sp > STACK_LIMIT);
    assign can_pop1  = (sp != SP_INIT);
    assign can_pop2  = ((SP_INIT - sp) >= ADDR_W'(2));

endmodule

// File: rtl/data_memory_responder.sv
// Data-memory responder for the pipeline memory stage. Owns the 16-bit word
// RAM and the stack pointer; services narrow load/store/push/pop and wide
// (32-bit) push/pop used for PC save/restore.
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   mem_read/mem_write         : narrow load/store at addr
//   mem_push/mem_pop, wide     : stack ops, 32-bit when wide=1
//   addr[15:0], wdata[31:0]    : word address (upper bits ignored), store data
//   rdata, rdata_valid         : registered result and its one-cycle strobe
//   busy                       : second cycle of a wide op; upstream stalls
//   sp                         : current stack pointer
//   stack_fault                : one-cycle pulse for a rejected request
//
// state   | meaning
// IDLE    | accepting requests; narrow ops and first half of wide ops
// PUSH_LO | wide push: high word written, writing low word at sp-1
// POP_HI  | wide pop: low word latched, reading high word at sp+2
module data_memory_responder
    import dmem_pkg::*;
#(
    parameter int unsigned       ADDR_W      = DEF_ADDR_W,
    parameter logic [ADDR_W-1:0] SP_INIT     = DEF_SP_INIT,
    parameter logic [ADDR_W-1:0] STACK_LIMIT = DEF_STACK_LIMIT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              mem_push,
    input  logic              mem_pop,
    input  logic              wide,
    input  logic [15:0]       addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              rdata_valid,
    output logic              busy,
    output logic [ADDR_W-1:0] sp,
    output logic              stack_fault
);

    logic [15:0] mem [0:(1<<ADDR_W)-1];

    state_e            state;
    op_e               op;
    logic [15:0]       word_latch;
    logic [ADDR_W-1:0] word_addr;
    logic [ADDR_W-1:0] sp_p1;
    logic [ADDR_W-1:0] sp_p2;
    logic [ADDR_W-1:0] sp_m1;
    logic              addr_unused;

    logic              sp_inc1, sp_inc2, sp_dec1, sp_dec2;
    logic              can_push1, can_push2, can_pop1, can_pop2;

    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [15:0]       ram_wdata;

    assign word_addr   = addr[ADDR_W-1:0];
    assign addr_unused = ^addr[15:ADDR_W];
    assign sp_p1       = sp + ADDR_W'(1);
    assign sp_p2       = sp + ADDR_W'(2);
    assign sp_m1       = sp - ADDR_W'(1);
    assign op          = decode_op(mem_read, mem_write, mem_push, mem_pop);

    stack_pointer_unit #(
        .ADDR_W     (ADDR_W),
        .SP_INIT    (SP_INIT),
        .STACK_LIMIT(STACK_LIMIT)
    ) u_spu (
        .clk      (clk),
        .reset    (reset),
        .inc1     (sp_inc1),
        .inc2     (sp_inc2),
        .dec1     (sp_dec1),
        .dec2     (sp_dec2),
        .sp       (sp),
        .can_push1(can_push1),
        .can_push2(can_push2),
        .can_pop1 (can_pop1),
        .can_pop2 (can_pop2)
    );

    // RAM write port and sp steps. Gated by reset so a reset landing on
    // PUSH_LO abandons the low-word write.
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = '0;
        ram_wdata = '0;
        sp_inc1   = 1'b0;
        sp_inc2   = 1'b0;
        sp_dec1   = 1'b0;
        sp_dec2   = 1'b0;
        if (!reset) begin
            case (state)
                IDLE: begin
                    case (op)
                        OP_WRITE: begin
                            ram_we    = 1'b1;
                            ram_waddr = word_addr;
                            ram_wdata = wdata[15:0];
                        end
                        OP_PUSH: begin
                            if (!wide && can_push1) begin
                                ram_we    = 1'b1;
                                ram_waddr = sp;
                                ram_wdata = wdata[15:0];
                                sp_dec1   = 1'b1;
                            end else if (wide && can_push2) begin
                                ram_we    = 1'b1;
                                ram_waddr = sp;
                                ram_wdata = wdata[31:16];
                            end
                        end
                        OP_POP: begin
                            if (!wide && can_pop1) begin
                                sp_inc1 = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
                PUSH_LO: begin
                    ram_we    = 1'b1;
                    ram_waddr = sp_m1;
                    ram_wdata = word_latch;
                    sp_dec2   = 1'b1;
                end
                POP_HI: begin
                    sp_inc2 = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[ram_waddr] <= ram_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            rdata       <= '0;
            rdata_valid <= 1'b0;
            busy        <= 1'b0;
            stack_fault <= 1'b0;
            word_latch  <= '0;
        end else begin
            rdata_valid <= 1'b0;
            stack_fault <= 1'b0;
            case (state)
                IDLE: begin
                    case (op)
                        OP_READ: begin
                            rdata       <= {16'h0000, mem[word_addr]};
                            rdata_valid <= 1'b1;
                        end
                        OP_PUSH: begin
                            if (wide) begin
                                if (can_push2) begin
                                    word_latch <= wdata[15:0];
                                    busy       <= 1'b1;
                                    state      <= PUSH_LO;
                                end else begin
                                    stack_fault <= 1'b1;
                                end
                            end else if (!can_push1) begin
                                stack_fault <= 1'b1;
                            end
                        end
                        OP_POP: begin
                            if (wide) begin
                                if (can_pop2) begin
                                    word_latch <= mem[sp_p1];
                                    busy       <= 1'b1;
                                    state      <= POP_HI;
                                end else begin
                                    stack_fault <= 1'b1;
                                end
                            end else if (can_pop1) begin
                                rdata       <= {16'h0000, mem[sp_p1]};
                                rdata_valid <= 1'b1;
                            end else begin
                                stack_fault <= 1'b1;
                            end
                        end
                        OP_MULTI: begin
                            stack_fault <= 1'b1;
                        end
                        default: ;
                    endcase
                end
                PUSH_LO: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                POP_HI: begin
                    rdata       <= {mem[sp_p2], word_latch};
                    rdata_valid <= 1'b1;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench for data_memory_responder: a table of one-cycle vectors
// with hand-computed outputs, then hand-written stack-limit and reset
// sequences.
module tb_data_memory_responder;

    logic        clk;
    logic        reset;
    logic        mem_read, mem_write, mem_push, mem_pop, wide;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        busy;
    logic [10:0] sp;
    logic        stack_fault;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        string       name;
        logic        rd, wr, pu, po, wd;
        logic [15:0] a;
        logic [31:0] d;
        logic [31:0] e_rdata;
        logic        e_valid, e_busy, e_fault;
        logic [10:0] e_sp;
    } vec_t;

    vec_t vecs[$];

    data_memory_responder dut (
        .clk        (clk),
        .reset      (reset),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_push   (mem_push),
        .mem_pop    (mem_pop),
        .wide       (wide),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .rdata_valid(rdata_valid),
        .busy       (busy),
        .sp         (sp),
        .stack_fault(stack_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] er, input logic ev,
                         input logic eb, input logic ef, input logic [10:0] es);
        n_vec++;
        if (rdata !== er) begin
            n_err++;
            $display("FAIL %s rdata got %h want %h", nm, rdata, er);
        end
        if (rdata_valid !== ev) begin
            n_err++;
            $display("FAIL %s rdata_valid got %b want %b", nm, rdata_valid, ev);
        end
        if (busy !== eb) begin
            n_err++;
            $display("FAIL %s busy got %b want %b", nm, busy, eb);
        end
        if (stack_fault !== ef) begin
            n_err++;
            $display("FAIL %s stack_fault got %b want %b", nm, stack_fault, ef);
        end
        if (sp !== es) begin
            n_err++;
            $display("FAIL %s sp got %h want %h", nm, sp, es);
        end
    endtask

    // Hold one request for one edge, then sample 1 time unit after the edge.
    task automatic apply(input logic r, input logic w, input logic pu, input logic po,
                         input logic wd, input logic [15:0] a, input logic [31:0] d);
        mem_read  = r;
        mem_write = w;
        mem_push  = pu;
        mem_pop   = po;
        wide      = wd;
        addr      = a;
        wdata     = d;
        @(posedge clk);
        #1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_push  = 1'b0;
        mem_pop   = 1'b0;
        wide      = 1'b0;
        addr      = '0;
        wdata     = '0;
    endtask

    task automatic add(input string nm, input logic r, input logic w, input logic pu,
                       input logic po, input logic wd, input logic [15:0] a,
                       input logic [31:0] d, input logic [31:0] er, input logic ev,
                       input logic eb, input logic ef, input logic [10:0] es);
        vecs.push_back('{nm, r, w, pu, po, wd, a, d, er, ev, eb, ef, es});
    endtask

    initial begin
        reset = 1'b1;
        mem_read = 0; mem_write = 0; mem_push = 0; mem_pop = 0; wide = 0;
        addr = '0; wdata = '0;

        //   name              rd wr pu po wd addr      wdata          rdata        v  b  f  sp
        add("idle",            0, 0, 0, 0, 0, 16'h0000, 32'h0,         32'h0,       0, 0, 0, 11'h7FF);
        add("write_10",        0, 1, 0, 0, 0, 16'h0010, 32'h0000_1234, 32'h0,       0, 0, 0, 11'h7FF);
        add("read_10",         1, 0, 0, 0, 0, 16'h0010, 32'h0,         32'h1234,    1, 0, 0, 11'h7FF);
        add("read_valid_drop", 0, 0, 0, 0, 0, 16'h0000, 32'h0,         32'h1234,    0, 0, 0, 11'h7FF);
        add("push_abcd",       0, 0, 1, 0, 0, 16'h0000, 32'h0000_ABCD, 32'h1234,    0, 0, 0, 11'h7FE);
        add("read_7ff",        1, 0, 0, 0, 0, 16'h07FF, 32'h0,         32'hABCD,    1, 0, 0, 11'h7FE);
        add("pop_abcd",        0, 0, 0, 1, 0, 16'h0000, 32'h0,         32'hABCD,    1, 0, 0, 11'h7FF);
        add("pop_empty",       0, 0, 0, 1, 0, 16'h0000, 32'h0,         32'hABCD,    0, 0, 1, 11'h7FF);
        add("fault_drop",      0, 0, 0, 0, 0, 16'h0000, 32'h0,         32'hABCD,    0, 0, 0, 11'h7FF);
        add("wpush_hi",        0, 0, 1, 0, 1, 16'h0000, 32'hDEAD_BEEF, 32'hABCD,    0, 1, 0, 11'h7FF);
        add("wpush_lo",        0, 0, 0, 0, 0, 16'h0000, 32'h0,         32'hABCD,    0, 0, 0, 11'h7FD);
        add("read_hi_word",    1, 0, 0, 0, 0, 16'h07FF, 32'h0,         32'hDEAD,    1, 0, 0, 11'h7FD);
        add("read_lo_word",    1, 0, 0, 0, 0, 16'h07FE, 32'h0,         32'hBEEF,    1, 0, 0, 11'h7FD);
        add("wpop_lo",         0, 0, 0, 1, 1, 16'h0000, 32'h0,         32'hBEEF,    0, 1, 0, 11'h7FD);
        add("wpop_hi",         0, 0, 0, 0, 0, 16'h0000, 32'h0,         32'hDEAD_BEEF, 1, 0, 0, 11'h7FF);
        add("read_plus_push",  1, 0, 1, 0, 0, 16'h0010, 32'h0000_9999, 32'hDEAD_BEEF, 0, 0, 1, 11'h7FF);
        add("multi_no_write",  1, 0, 0, 0, 0, 16'h07FF, 32'h0,         32'hDEAD,    1, 0, 0, 11'h7FF);
        add("wpop_empty",      0, 0, 0, 1, 1, 16'h0000, 32'h0,         32'hDEAD,    0, 0, 1, 11'h7FF);
        add("push_1111",       0, 0, 1, 0, 0, 16'h0000, 32'h0000_1111, 32'hDEAD,    0, 0, 0, 11'h7FE);
        add("wpop_one_word",   0, 0, 0, 1, 1, 16'h0000, 32'h0,         32'hDEAD,    0, 0, 1, 11'h7FE);
        add("pop_1111",        0, 0, 0, 1, 0, 16'h0000, 32'h0,         32'h1111,    1, 0, 0, 11'h7FF);
        add("write_hi_addr",   0, 1, 0, 0, 0, 16'hF820, 32'hFFFF_5A5A, 32'h1111,    0, 0, 0, 11'h7FF);
        add("read_20",         1, 0, 0, 0, 0, 16'h0020, 32'h0,         32'h5A5A,    1, 0, 0, 11'h7FF);

        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", 32'h0, 1'b0, 1'b0, 1'b0, 11'h7FF);

        foreach (vecs[i]) begin
            apply(vecs[i].rd, vecs[i].wr, vecs[i].pu, vecs[i].po, vecs[i].wd,
                  vecs[i].a, vecs[i].d);
            check(vecs[i].name, vecs[i].e_rdata, vecs[i].e_valid, vecs[i].e_busy,
                  vecs[i].e_fault, vecs[i].e_sp);
        end

        // Stack floor: fill down to sp=0x400, then probe both push widths.
        apply(0, 1, 0, 0, 0, 16'h0400, 32'h0000_7777);
        apply(0, 1, 0, 0, 0, 16'h03FF, 32'h0000_6666);
        for (int i = 0; i < 'h3FF; i++) begin
            apply(0, 0, 1, 0, 0, 16'h0000, 32'(i));
        end
        check("filled_to_400", 32'h5A5A, 1'b0, 1'b0, 1'b0, 11'h400);
        apply(0, 0, 1, 0, 1, 16'h0000, 32'h1234_5678);
        check("wpush_at_400", 32'h5A5A, 1'b0, 1'b0, 1'b1, 11'h400);
        apply(1, 0, 0, 0, 0, 16'h0400, 32'h0);
        check("floor_untouched", 32'h7777, 1'b1, 1'b0, 1'b0, 11'h400);
        apply(0, 0, 1, 0, 0, 16'h0000, 32'h0000_8888);
        check("push_at_400", 32'h7777, 1'b0, 1'b0, 1'b0, 11'h3FF);
        apply(0, 0, 1, 0, 0, 16'h0000, 32'h0000_4444);
        check("push_at_3ff", 32'h7777, 1'b0, 1'b0, 1'b1, 11'h3FF);
        apply(1, 0, 0, 0, 0, 16'h0400, 32'h0);
        check("read_400", 32'h8888, 1'b1, 1'b0, 1'b0, 11'h3FF);
        apply(1, 0, 0, 0, 0, 16'h03FF, 32'h0);
        check("read_3ff", 32'h6666, 1'b1, 1'b0, 1'b0, 11'h3FF);

        // Reset landing on PUSH_LO.
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset_again", 32'h0, 1'b0, 1'b0, 1'b0, 11'h7FF);
        apply(0, 1, 0, 0, 0, 16'h07FE, 32'h0000_5555);
        apply(0, 0, 1, 0, 1, 16'h0000, 32'hCAFE_F00D);
        check("wpush_busy", 32'h0, 1'b0, 1'b1, 1'b0, 11'h7FF);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset_in_push_lo", 32'h0, 1'b0, 1'b0, 1'b0, 11'h7FF);
        apply(1, 0, 0, 0, 0, 16'h07FF, 32'h0);
        check("hi_word_kept", 32'hCAFE, 1'b1, 1'b0, 1'b0, 11'h7FF);
        apply(1, 0, 0, 0, 0, 16'h07FE, 32'h0);
        check("lo_word_untouched", 32'h5555, 1'b1, 1'b0, 1'b0, 11'h7FF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
